// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Purpose: Shared definitions for the fetch stage: FSM state encoding,
//          the canonical NOP encoding and the default reset PC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    EXEC  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Purpose: Instruction fetch stage. Owns the architectural PC, issues one
//          instruction-memory request at a time, buffers the returned word
//          for decode and commits the IFU-computed next PC on completion.
// Config : FETCH_MISALIGN_TRAP_EN - when defined, a commit of a misaligned
//          pc_next is refused and flagged on fetch_misalign; otherwise the
//          low two bits of pc_next are cleared on commit.
// Ports  : clk, rst_n           clock, async active-low reset
//          pc_next, pc_update   next PC from IFU / execute-done strobe
//          pc                   architectural PC
//          imem_req_valid/ready, imem_addr      request channel
//          imem_rsp_valid, imem_rsp_data        response channel
//          inst_valid/ready, inst, inst_pc      decode channel
//          fetch_misalign       misaligned-fetch trap pulse
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next,
  input  logic            pc_update,
  output logic [XLEN-1:0] pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misalign
);

`ifndef FETCH_MISALIGN_TRAP_EN
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(3);
`endif

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic            misalign_q, misalign_d;
  logic            commit;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = 1'b0;
    commit     = 1'b0;

    case (state_q)
      // req_valid_q gates the handshake so that the cycle right after reset
      // release, where the request is not yet visible, cannot be accepted.
      REQ:     if (req_valid_q && imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d    = imem_rsp_data;
          inst_pc_d = pc_q;
          state_d   = ISSUE;
        end
      end
      // pc_update only counts in ISSUE when decode takes the word this cycle.
      ISSUE: begin
        if (inst_ready) begin
          if (pc_update) commit = 1'b1;
          else           state_d = EXEC;
        end
      end
      EXEC:    if (pc_update) commit = 1'b1;
      default: state_d = REQ;
    endcase

    if (commit) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (pc_next[1:0] != 2'b00) begin
        // Keep the old PC and wait in EXEC for the trap-vector commit.
        misalign_d = 1'b1;
        state_d    = EXEC;
      end else begin
        pc_d    = pc_next;
        state_d = REQ;
      end
`else
      pc_d    = pc_next & PC_ALIGN_MASK;
      state_d = REQ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= (state_d == REQ);
      inst_valid_q <= (state_d == ISSUE);
      misalign_q   <= misalign_d;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign imem_req_valid = req_valid_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_misalign = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Purpose: Self-checking bench for fetch_unit. Table of fetch transactions
//          plus hand-written reset-abort and misaligned-commit sequences.
//          Honours FETCH_MISALIGN_TRAP_EN in its expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        pc_update;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_misalign;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next        (pc_next),
    .pc_update      (pc_update),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rsp_data;
    logic [31:0] pc_next;
    int          req_stall;
    int          rsp_wait;
    int          inst_stall;
    bit          with_ready;
    bit          spur;
    logic [31:0] exp_inst_pc;
    logic [31:0] exp_next;
    logic [31:0] trap_pc;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] last_inst;
  vec_t        vecs[6];
  vec_t        vpost;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one full fetch transaction starting from a REQ-state negedge.
  task automatic do_fetch(input vec_t v);
    int   t0;
    int   n;
    sb_t  e;
    t0 = cyc;
    chk("req_valid_start", imem_req_valid, 1'b1);
    chk("req_addr", imem_addr, v.exp_inst_pc);
    chk("pc_out", pc, v.exp_inst_pc);

    for (int k = 0; k < v.req_stall; k++) begin
      imem_req_ready = 1'b0;
      if (v.spur) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hbad0_bad0;
      end
      step();
      imem_rsp_valid = 1'b0;
      chk("req_hold", imem_req_valid, 1'b1);
      chk("addr_stable", imem_addr, v.exp_inst_pc);
      chk("inst_hold", inst, last_inst);
    end

    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("no_dup_req", imem_req_valid, 1'b0);

    for (int k = 0; k < v.rsp_wait; k++) begin
      if (v.spur) begin
        pc_update = 1'b1;
        pc_next   = 32'h0000_3000;
      end
      step();
      pc_update = 1'b0;
      chk("wait_no_inst", inst_valid, 1'b0);
      chk("wait_pc_hold", imem_addr, v.exp_inst_pc);
    end

    imem_rsp_valid = 1'b1;
    imem_rsp_data  = v.rsp_data;
    sb.push_back('{inst: v.rsp_data, pc: v.exp_inst_pc});
    step();
    imem_rsp_valid = 1'b0;

    n = 0;
    while (!inst_valid && n < 8) begin
      step();
      n++;
    end
    n_chk++;
    if (!inst_valid) begin
      n_fail++;
      $display("FAIL inst_valid_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got inst %h expected none", inst);
    end else begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("inst_pc", inst_pc, e.pc);
    end
    last_inst = v.rsp_data;

    for (int k = 0; k < v.inst_stall; k++) begin
      inst_ready = 1'b0;
      step();
      chk("inst_valid_hold", inst_valid, 1'b1);
      chk("inst_stable", inst, v.rsp_data);
    end

    inst_ready = 1'b1;
    pc_next    = v.pc_next;
    if (v.with_ready) pc_update = 1'b1;
    step();
    inst_ready = 1'b0;
    if (!v.with_ready) begin
      chk("exec_no_valid", inst_valid, 1'b0);
      chk("exec_no_req", imem_req_valid, 1'b0);
      pc_update = 1'b1;
      step();
    end
    pc_update = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
    if (v.pc_next[1:0] != 2'b00) begin
      chk("misalign_pulse", fetch_misalign, 1'b1);
      chk("misalign_no_req", imem_req_valid, 1'b0);
      chk("misalign_pc_kept", pc, v.exp_inst_pc);
      step();
      chk("misalign_one_cycle", fetch_misalign, 1'b0);
      pc_update = 1'b1;
      pc_next   = v.trap_pc;
      step();
      pc_update = 1'b0;
    end
`endif

    chk("misalign_low", fetch_misalign, 1'b0);
    chk("next_req_valid", imem_req_valid, 1'b1);
    chk("next_addr", imem_addr, v.exp_next);
    chk("inst_after_commit", inst, v.rsp_data);
    if (v.exp_cycles != 0) chk("loop_cycles", 32'(cyc - t0), 32'(v.exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            data          pc_next       rs rw is rdy spur inst_pc       next          trap          cyc
    vecs[0] = '{32'h0050_0093, 32'h0000_0104, 0, 0, 0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0, 3};
    vecs[1] = '{32'h00a0_0113, 32'h0000_0108, 0, 0, 0, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0108, 32'h0, 3};
    vecs[2] = '{32'hdead_beef, 32'h0000_010c, 4, 0, 2, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_010c, 32'h0, 10};
    vecs[3] = '{32'h1234_5678, 32'h0000_0200, 0, 0, 0, 1'b0, 1'b0, 32'h0000_010c, 32'h0000_0200, 32'h0, 4};
    vecs[4] = '{32'h0010_0073, 32'hffff_fffc, 2, 2, 0, 1'b1, 1'b1, 32'h0000_0200, 32'hffff_fffc, 32'h0, 7};
    vecs[5] = '{32'h0000_0513, 32'h0000_0000, 0, 1, 0, 1'b1, 1'b0, 32'hffff_fffc, 32'h0000_0000, 32'h0, 4};
`ifdef FETCH_MISALIGN_TRAP_EN
    vpost   = '{32'h0050_0093, 32'h0000_0106, 0, 0, 0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'h0000_0200, 0};
`else
    vpost   = '{32'h0050_0093, 32'h0000_0106, 0, 0, 0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0, 3};
`endif

    rst_n          = 1'b0;
    pc_next        = '0;
    pc_update      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    last_inst      = 32'h0000_0013;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_misalign", fetch_misalign, 1'b0);
    rst_n = 1'b1;
    step();
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    chk("first_inst", inst, 32'h0000_0013);

    for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

    // Reset asserted while a request is outstanding
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("abort_in_wait", imem_req_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_valid", imem_req_valid, 1'b0);
    chk("abort_inst_valid", inst_valid, 1'b0);
    chk("abort_inst", inst, 32'h0000_0013);
    chk("abort_inst_pc", inst_pc, 32'h0);
    chk("abort_addr", imem_addr, 32'h0000_0100);
    chk("abort_misalign", fetch_misalign, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    last_inst = 32'h0000_0013;
    step();
    chk("restart_req_valid", imem_req_valid, 1'b1);
    chk("restart_addr", imem_addr, 32'h0000_0100);

    // Misaligned commit right after restart
    do_fetch(vpost);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
